// File: rtl/accel_frame_server_pkg.sv
// Shared definitions for the accelerometer frame server: FSM encoding, default
// command bytes, the error response byte and the axis codes of the SPI reader.
package accel_frame_server_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [7:0] CMD_X_DEF   = 8'h78;
  localparam logic [7:0] CMD_Y_DEF   = 8'h79;
  localparam logic [7:0] CMD_Z_DEF   = 8'h7A;
  localparam logic [7:0] CMD_ALL_DEF = 8'h73;
  localparam logic [7:0] CMD_CLR_DEF = 8'h63;

  localparam logic [7:0] ERR_BYTE = 8'h3F;

  localparam logic [1:0] AXIS_X   = 2'd0;
  localparam logic [1:0] AXIS_Y   = 2'd1;
  localparam logic [1:0] AXIS_Z   = 2'd2;
  localparam logic [1:0] AXIS_INV = 2'd3;

  function automatic logic [7:0] byte_of(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/accel_shadow_regs.sv
// Shadow registers for the three axes plus sample counter; snapshot copy on snap_load.
// Latency: one cycle for shadows and snapshots; no backpressure (samples are never refused).
module accel_shadow_regs
  import accel_frame_server_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [1:0]  sample_axis,
  input  logic [15:0] sample_data,
  input  logic        snap_load,
  output logic [15:0] snap_x,
  output logic [15:0] snap_y,
  output logic [15:0] snap_z,
  output logic [7:0]  led
);

  logic [15:0] shx_q, shy_q, shz_q;
  logic [15:0] snx_q, sny_q, snz_q;
  logic [7:0]  cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      shx_q <= '0;
      shy_q <= '0;
      shz_q <= '0;
      snx_q <= '0;
      sny_q <= '0;
      snz_q <= '0;
      cnt_q <= '0;
    end else begin
      if (sample_valid && (sample_axis != AXIS_INV)) begin
        cnt_q <= cnt_q + 8'd1;
        case (sample_axis)
          AXIS_X:  shx_q <= sample_data;
          AXIS_Y:  shy_q <= sample_data;
          default: shz_q <= sample_data;
        endcase
      end
      // Snapshot reads the pre-edge shadows, so a same-cycle sample is not seen.
      if (snap_load) begin
        snx_q <= shx_q;
        sny_q <= shy_q;
        snz_q <= shz_q;
      end
    end
  end

  assign snap_x = snx_q;
  assign snap_y = sny_q;
  assign snap_z = snz_q;
  assign led    = cnt_q;

endmodule

// File: rtl/accel_frame_server.sv
// Serves accelerometer samples as byte frames to a command port; 2-cycle command-to-first-byte.
// Commands only accepted in IDLE (others set overrun); tx_byte held while tx_ready is low.
module accel_frame_server
  import accel_frame_server_pkg::*;
#(
  parameter logic [7:0] CMD_X   = CMD_X_DEF,
  parameter logic [7:0] CMD_Y   = CMD_Y_DEF,
  parameter logic [7:0] CMD_Z   = CMD_Z_DEF,
  parameter logic [7:0] CMD_ALL = CMD_ALL_DEF,
  parameter logic [7:0] CMD_CLR = CMD_CLR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [1:0]  sample_axis,
  input  logic [15:0] sample_data,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  output logic [1:0]  axis_sel,
  output logic [7:0]  led,
  output logic        overrun
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  axis_sel_q, axis_sel_d;
  logic        all_q, all_d;
  logic [2:0]  idx_q, idx_d;
  logic        overrun_q, overrun_d;
  logic [15:0] snap_x, snap_y, snap_z;
  logic [15:0] cur_word;
  logic [2:0]  last_idx;

  accel_shadow_regs u_shadow (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_axis  (sample_axis),
    .sample_data  (sample_data),
    .snap_load    (state_q == ST_LOAD),
    .snap_x       (snap_x),
    .snap_y       (snap_y),
    .snap_z       (snap_z),
    .led          (led)
  );

  assign rx_ready = (state_q == ST_IDLE);
  assign tx_valid = (state_q == ST_SEND) || (state_q == ST_ERR);
  assign axis_sel = axis_sel_q;
  assign overrun  = overrun_q;
  assign last_idx = all_q ? 3'd5 : 3'd1;

  // Full frame walks X,Y,Z by byte pair; single-axis frame uses the commanded axis.
  always_comb begin
    cur_word = snap_x;
    if (all_q) begin
      case (idx_q[2:1])
        2'd0:    cur_word = snap_x;
        2'd1:    cur_word = snap_y;
        default: cur_word = snap_z;
      endcase
    end else begin
      case (axis_sel_q)
        AXIS_X:  cur_word = snap_x;
        AXIS_Y:  cur_word = snap_y;
        default: cur_word = snap_z;
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    if (state_q == ST_SEND) begin
      tx_byte = byte_of(cur_word, idx_q[0]);
    end else if (state_q == ST_ERR) begin
      tx_byte = ERR_BYTE;
    end
  end

  always_comb begin
    state_d    = state_q;
    axis_sel_d = axis_sel_q;
    all_d      = all_q;
    idx_d      = idx_q;
    overrun_d  = overrun_q;
    if (rx_valid && !rx_ready) begin
      overrun_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          idx_d = 3'd0;
          if (rx_byte == CMD_X) begin
            axis_sel_d = AXIS_X;
            all_d      = 1'b0;
            state_d    = ST_LOAD;
          end else if (rx_byte == CMD_Y) begin
            axis_sel_d = AXIS_Y;
            all_d      = 1'b0;
            state_d    = ST_LOAD;
          end else if (rx_byte == CMD_Z) begin
            axis_sel_d = AXIS_Z;
            all_d      = 1'b0;
            state_d    = ST_LOAD;
          end else if (rx_byte == CMD_ALL) begin
            all_d   = 1'b1;
            state_d = ST_LOAD;
          end else if (rx_byte == CMD_CLR) begin
            overrun_d = 1'b0;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_LOAD: begin
        idx_d   = 3'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q == last_idx) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      axis_sel_q <= AXIS_X;
      all_q      <= 1'b0;
      idx_q      <= 3'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      axis_sel_q <= axis_sel_d;
      all_q      <= all_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_accel_frame_server.sv
// Scoreboard bench: stimulus queues expected response bytes, a negedge monitor pops on handshake.
module tb_accel_frame_server;

  logic        clock;
  logic        reset;
  logic        sample_valid;
  logic [1:0]  sample_axis;
  logic [15:0] sample_data;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic [1:0]  axis_sel;
  logic [7:0]  led;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  accel_frame_server dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_axis  (sample_axis),
    .sample_data  (sample_data),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .tx_valid     (tx_valid),
    .tx_byte      (tx_byte),
    .tx_ready     (tx_ready),
    .axis_sel     (axis_sel),
    .led          (led),
    .overrun      (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Handshake completes at the next rising edge; sampled half a cycle earlier.
  always @(negedge clock) begin
    logic [7:0] exp;
    if (!reset && tx_valid && tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h, no byte expected", tx_byte);
      end else begin
        exp = exp_q.pop_front();
        if (tx_byte !== exp) begin
          errors++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_byte, exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input logic [1:0] axis, input logic [15:0] data);
    sample_valid = 1'b1;
    sample_axis  = axis;
    sample_data  = data;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 100) begin
      step();
      n++;
    end
    check("drain_done", {31'd0, (n < 100)}, 32'd1);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_axis  = 2'd0;
    sample_data  = 16'h0000;
    rx_valid     = 1'b0;
    rx_byte      = 8'h00;
    tx_ready     = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_axis_sel", axis_sel, 0);
    check("rst_led", led, 0);
    check("rst_overrun", overrun, 0);

    // Single Y axis first so axis_sel moves away from 0.
    sample(2'd1, 16'hABCD);
    check("led_after_1", led, 8'h01);
    exp_q.push_back(8'hCD);
    exp_q.push_back(8'hAB);
    cmd(8'h79);
    drain();
    check("axis_sel_y", axis_sel, 1);

    // Single X axis with latency checks.
    sample(2'd0, 16'h1234);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    cmd(8'h78);
    check("load_tx_valid", tx_valid, 0);
    check("load_rx_ready", rx_ready, 0);
    step();
    check("first_tx_valid", tx_valid, 1);
    check("first_tx_byte", tx_byte, 8'h34);
    drain();
    check("axis_sel_x", axis_sel, 0);
    check("idle_after_x", rx_ready, 1);

    // Coherent frame; Z sample during LOAD must not reach the snapshot.
    sample(2'd0, 16'h0102);
    sample(2'd1, 16'h0304);
    sample(2'd2, 16'h0506);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h05);
    cmd(8'h73);
    sample(2'd2, 16'hFFFF);
    drain();
    check("axis_sel_after_all", axis_sel, 0);

    // Backpressure: five stalled cycles on the first byte.
    tx_ready = 1'b0;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    cmd(8'h78);
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_tx_valid", tx_valid, 1);
      check("stall_tx_byte", tx_byte, 8'h02);
      step();
    end
    tx_ready = 1'b1;
    drain();

    // Unknown command gives a single error byte.
    exp_q.push_back(8'h3F);
    cmd(8'h41);
    check("err_tx_byte", tx_byte, 8'h3F);
    drain();
    check("err_back_idle", rx_ready, 1);

    // Overrun: CLR byte while busy is dropped and still flags overrun.
    tx_ready = 1'b0;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    cmd(8'h78);
    step();
    cmd(8'h63);
    check("overrun_set", overrun, 1);
    tx_ready = 1'b1;
    drain();
    check("overrun_sticky", overrun, 1);
    cmd(8'h63);
    check("overrun_clr", overrun, 0);
    check("clr_no_tx", tx_valid, 0);
    check("clr_rx_ready", rx_ready, 1);
    step();
    check("clr_no_tx_late", tx_valid, 0);

    // Counter wrap, invalid-axis strobes do not count.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("led_reset", led, 0);
    sample_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      sample_axis = 2'(i % 3);
      sample_data = 16'(i);
      step();
    end
    sample_valid = 1'b0;
    check("led_ff", led, 8'hFF);
    sample_valid = 1'b1;
    sample_axis  = 2'd3;
    repeat (3) step();
    sample_valid = 1'b0;
    check("led_axis3_ignored", led, 8'hFF);
    sample(2'd0, 16'h5555);
    check("led_wrap", led, 8'h00);

    // Reset mid-frame aborts it.
    tx_ready = 1'b0;
    cmd(8'h73);
    step();
    check("pre_abort_tx_valid", tx_valid, 1);
    check("pre_abort_tx_byte", tx_byte, 8'h55);
    reset = 1'b1;
    step();
    check("abort_tx_valid", tx_valid, 0);
    check("abort_tx_byte", tx_byte, 0);
    check("abort_led", led, 0);
    reset = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_tx", tx_valid, 0);
      step();
    end

    // Shadows were cleared by reset.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    cmd(8'h7A);
    drain();
    check("axis_sel_z", axis_sel, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_frame_server.md
ACCEL_FRAME_SERVER -- requirements
Module: accel_frame_server

Interface
REQ-001 Parameter CMD_X, default 8'h78, command byte selecting X axis.
REQ-002 Parameter CMD_Y, default 8'h79, command byte selecting Y axis.
REQ-003 Parameter CMD_Z, default 8'h7A, command byte selecting Z axis.
REQ-004 Parameter CMD_ALL, default 8'h73, command byte requesting coherent X,Y,Z frame.
REQ-005 Parameter CMD_CLR, default 8'h63, command byte clearing status.
REQ-006 clock  in  1  single system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 sample_valid  in  1  one-cycle strobe from SPI accelerometer reader.
REQ-009 sample_axis  in  2  axis of strobed sample: 0=X, 1=Y, 2=Z, 3=invalid.
REQ-010 sample_data  in  16  signed accelerometer sample.
REQ-011 rx_valid  in  1  command byte present from parallel receiver.
REQ-012 rx_byte  in  8  command byte.
REQ-013 rx_ready  out  1  block accepts command this cycle.
REQ-014 tx_valid  out  1  response byte present for parallel transmitter.
REQ-015 tx_byte  out  8  response byte.
REQ-016 tx_ready  in  1  transmitter consumes tx_byte this cycle.
REQ-017 axis_sel  out  2  axis last commanded, driven to SPI reader.
REQ-018 led  out  8  sample counter, to board LEDs.
REQ-019 overrun  out  1  sticky: command byte dropped.

Function
REQ-020 Shadow registers X,Y,Z SHALL load sample_data on sample_valid for axis 0/1/2; axis 3 ignored, counter not incremented.
REQ-021 led SHALL increment by 1 per accepted sample, wrapping 8'hFF->8'h00.
REQ-022 FSM states IDLE, LOAD, SEND, ERR; rx_ready=1 only in IDLE.
REQ-023 IDLE + rx_valid: CMD_X/Y/Z -> LOAD, axis_sel updated next edge; CMD_ALL -> LOAD; CMD_CLR -> clear overrun, stay IDLE, no response; other -> ERR.
REQ-024 LOAD (one cycle) SHALL copy required shadow values into snapshot registers; snapshot captures shadow value before any same-cycle sample_valid update.
REQ-025 SEND SHALL present bytes low-then-high: single axis 2 bytes; CMD_ALL 6 bytes X_lo,X_hi,Y_lo,Y_hi,Z_lo,Z_hi.
REQ-026 tx_valid SHALL assert first cycle after LOAD; tx_byte stable while tx_valid && !tx_ready; byte index advances only on tx_valid && tx_ready.
REQ-027 After final byte handshake, FSM SHALL return to IDLE with tx_valid=0 next cycle.
REQ-028 ERR SHALL present tx_byte=8'h3F once with same handshake, then IDLE.
REQ-029 Min command-to-first-byte latency 2 cycles (accept edge, LOAD edge).
REQ-030 Samples arriving during LOAD/SEND/ERR SHALL update shadows only; snapshot frozen until next LOAD.
REQ-031 rx_valid while rx_ready=0 SHALL set overrun; byte discarded; set wins over CMD_CLR only if same cycle impossible (CLR only in IDLE).

Reset
REQ-032 On reset: FSM IDLE, tx_valid=0, tx_byte=0, rx_ready=1 next cycle, axis_sel=0, led=0, overrun=0, shadows and snapshots=0.
REQ-033 Reset mid-SEND SHALL abort frame; no further bytes presented.

Structure
REQ-034 Shared package: FSM state encoding, command byte defaults, ERR byte 8'h3F, axis codes.
REQ-035 One sub-module natural: accel_shadow_regs (three 16-bit shadows, counter, snapshot copy).

Verification
REQ-036 Samples X=16'h1234 then rx 8'h78, tx_ready=1 -> tx_byte 8'h34 then 8'h12, axis_sel=0.
REQ-037 X=16'h0102,Y=16'h0304,Z=16'h0506, rx 8'h73 -> bytes 02,01,04,03,06,05; Z=16'hFFFF mid-frame does not alter output.
REQ-038 tx_ready held 0 for 5 cycles after first byte -> tx_byte unchanged, tx_valid held, no byte skipped.
REQ-039 rx 8'h41 -> single tx_byte 8'h3F, then IDLE.
REQ-040 rx_valid during SEND -> overrun=1; rx 8'h63 in IDLE -> overrun=0, no tx_valid.
REQ-041 256 valid samples plus 3 axis-3 strobes -> led=8'h00; reset asserted during SEND -> tx_valid=0 next cycle, led=0.
